// File: rtl/serial_parity_checker_pkg.sv
// Shared definitions for the serial parity checker: FSM state encoding and parity modes.
package serial_parity_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_REPORT = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        REPORT = ST_REPORT
    } state_t;

    localparam logic EVEN_PARITY     = 1'b0;
    localparam logic ODD_PARITY_MODE = 1'b1;

endpackage

// File: rtl/serial_parity_checker_if.sv
// Serial-in / parallel-out bus of the parity checker; master drives the bit stream.
interface serial_parity_checker_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 frame_start;
    logic                 bit_in;
    logic                 bit_valid;
    logic [DATA_BITS-1:0] word_out;
    logic                 word_valid;
    logic                 parity_err;
    logic                 busy;
    logic                 frame_abort;

    modport master (
        output frame_start, bit_in, bit_valid,
        input  word_out, word_valid, parity_err, busy, frame_abort
    );

    modport slave (
        input  frame_start, bit_in, bit_valid,
        output word_out, word_valid, parity_err, busy, frame_abort
    );
endinterface

// File: rtl/serial_parity_checker_parity_accum.sv
// Single-bit XOR accumulator with synchronous clear (priority) and enable.
module parity_accum (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_i,
    output logic acc_o
);
    logic acc_q;
    logic acc_d;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = 1'b0;
        end else if (en_i) begin
            acc_d = acc_q ^ bit_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;
endmodule

// File: rtl/serial_parity_checker.sv
// Deserialises LSB-first frames of DATA_BITS data bits plus one parity bit,
// reporting the word and a parity-error flag for one cycle per completed frame.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    serial_parity_checker_if.slave  bus
);
    localparam int unsigned CW       = $clog2(DATA_BITS);
    localparam logic        PAR_MODE = (ODD_PARITY != 0) ? ODD_PARITY_MODE : EVEN_PARITY;
    localparam logic [CW-1:0] LAST   = CW'(DATA_BITS - 1);

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] word_q, word_d;
    logic                 perr_q, perr_d;
    logic                 abort_q, abort_d;
    logic                 acc;
    logic                 acc_clr;
    logic                 acc_en;

    parity_accum u_accum (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (acc_clr),
        .en_i  (acc_en),
        .bit_i (bus.bit_in),
        .acc_o (acc)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        perr_d  = perr_q;
        abort_d = 1'b0;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        // frame_start wins over bit_valid in every state; it aborts only an active frame
        if (bus.frame_start) begin
            abort_d = (state_q == DATA) || (state_q == PARITY);
            state_d = DATA;
            cnt_d   = '0;
            shift_d = '0;
            acc_clr = 1'b1;
        end else begin
            case (state_q)
                DATA: begin
                    if (bus.bit_valid) begin
                        shift_d[cnt_q] = bus.bit_in;
                        acc_en         = 1'b1;
                        if (cnt_q == LAST) begin
                            state_d = PARITY;
                        end else begin
                            cnt_d = cnt_q + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bus.bit_valid) begin
                        perr_d  = (acc ^ bus.bit_in) != PAR_MODE;
                        word_d  = shift_q;
                        state_d = REPORT;
                    end
                end
                REPORT:  state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            perr_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            perr_q  <= perr_d;
            abort_q <= abort_d;
        end
    end

    assign bus.word_out    = word_q;
    assign bus.parity_err  = perr_q;
    assign bus.frame_abort = abort_q;
    assign bus.word_valid  = (state_q == REPORT);
    assign bus.busy        = (state_q == DATA) || (state_q == PARITY);
endmodule

// File: tb/tb_serial_parity_checker.sv
// Drives one stimulus stream into an even- and an odd-parity checker and
// compares both against a frame-level model every cycle, plus literal checks.
module tb_serial_parity_checker;
    localparam int unsigned DB = 8;

    logic clk;
    logic rst_n;
    logic fs, bv, bi;
    int   total;
    int   bad;

    serial_parity_checker_if #(.DATA_BITS(DB)) bus_e ();
    serial_parity_checker_if #(.DATA_BITS(DB)) bus_o ();

    assign bus_e.frame_start = fs;
    assign bus_e.bit_valid   = bv;
    assign bus_e.bit_in      = bi;
    assign bus_o.frame_start = fs;
    assign bus_o.bit_valid   = bv;
    assign bus_o.bit_in      = bi;

    serial_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(0)) dut_e (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_e.slave)
    );

    serial_parity_checker #(.DATA_BITS(DB), .ODD_PARITY(1)) dut_o (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_o.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: collect bits of the open frame in a queue, and when
    // DATA_BITS+1 have arrived, build the word and check overall XOR.
    bit             m_active [2];
    bit             mq       [2][$];
    logic [DB-1:0]  exp_word [2];
    logic           exp_err  [2];
    logic           exp_wv   [2];
    logic           exp_ab   [2];
    logic           ab_t, wv_t, x_t;
    logic [DB-1:0]  w_t;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_active[k] = 1'b0;
                mq[k].delete();
                exp_word[k] = '0;
                exp_err[k]  = 1'b0;
                exp_wv[k]   = 1'b0;
                exp_ab[k]   = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                ab_t = 1'b0;
                wv_t = 1'b0;
                if (fs) begin
                    ab_t        = m_active[k];
                    m_active[k] = 1'b1;
                    mq[k].delete();
                end else if (m_active[k] && bv) begin
                    mq[k].push_back(bi);
                    if (mq[k].size() == DB + 1) begin
                        w_t = '0;
                        x_t = 1'b0;
                        for (int i = 0; i < int'(DB); i++) w_t[i] = mq[k][i];
                        for (int i = 0; i <= int'(DB); i++) x_t = x_t ^ mq[k][i];
                        exp_word[k] = w_t;
                        exp_err[k]  = (x_t != k[0]);
                        wv_t        = 1'b1;
                        m_active[k] = 1'b0;
                    end
                end
                exp_ab[k] = ab_t;
                exp_wv[k] = wv_t;
            end
        end
    end

    always @(negedge clk) begin
        chk("e.busy",        bus_e.busy,        m_active[0]);
        chk("e.word_valid",  bus_e.word_valid,  exp_wv[0]);
        chk("e.frame_abort", bus_e.frame_abort, exp_ab[0]);
        chk("e.word_out",    bus_e.word_out,    exp_word[0]);
        if (exp_wv[0]) chk("e.parity_err", bus_e.parity_err, exp_err[0]);
        chk("o.busy",        bus_o.busy,        m_active[1]);
        chk("o.word_valid",  bus_o.word_valid,  exp_wv[1]);
        chk("o.frame_abort", bus_o.frame_abort, exp_ab[1]);
        chk("o.word_out",    bus_o.word_out,    exp_word[1]);
        if (exp_wv[1]) chk("o.parity_err", bus_o.parity_err, exp_err[1]);
    end

    // One clock cycle with the given inputs; returns 1 time unit after the edge.
    task automatic cyc(input logic f, input logic v, input logic b);
        fs = f;
        bv = v;
        bi = b;
        @(posedge clk);
        #1;
        fs = 1'b0;
        bv = 1'b0;
        bi = 1'b0;
    endtask

    task automatic send_bits(input logic [DB-1:0] d, input int unsigned n, input int unsigned gap);
        for (int unsigned i = 0; i < n; i++) begin
            for (int unsigned g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0);
            cyc(1'b0, 1'b1, d[i]);
        end
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic p, input int unsigned gap);
        cyc(1'b1, 1'b1, 1'b1);
        send_bits(d, DB, gap);
        for (int unsigned g = 0; g < gap; g++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, p);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        fs    = 1'b0;
        bv    = 1'b0;
        bi    = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst.word_out",   bus_e.word_out,   0);
        chk("rst.word_valid", bus_e.word_valid, 0);
        chk("rst.busy",       bus_e.busy,       0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 1'b1);

        // 1: 0xA5, correct even parity
        send_frame(8'hA5, 1'b0, 0);
        chk("t1.word_valid", bus_e.word_valid, 1);
        chk("t1.word_out",   bus_e.word_out,   8'hA5);
        chk("t1.parity_err", bus_e.parity_err, 0);
        chk("t1.busy",       bus_e.busy,       0);

        // 2: bad parity, single-cycle pulse
        send_frame(8'hA5, 1'b1, 0);
        chk("t2.word_out",   bus_e.word_out,   8'hA5);
        chk("t2.parity_err", bus_e.parity_err, 1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t2.pulse_end",  bus_e.word_valid, 0);

        // 3: gapped bits
        cyc(1'b1, 1'b0, 1'b0);
        send_bits(8'h01, 3, 3);
        cyc(1'b0, 1'b0, 1'b0);
        chk("t3.busy_gap", bus_e.busy, 1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        send_bits(8'h00, 5, 3);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("t3.word_out",   bus_e.word_out,   8'h01);
        chk("t3.parity_err", bus_e.parity_err, 0);

        // 4: abort after four bits, then 0xFF
        cyc(1'b1, 1'b0, 1'b0);
        send_bits(8'h0F, 4, 0);
        cyc(1'b1, 1'b1, 1'b0);
        chk("t4.abort",      bus_e.frame_abort, 1);
        chk("t4.no_valid",   bus_e.word_valid,  0);
        chk("t4.word_hold",  bus_e.word_out,    8'h01);
        send_bits(8'hFF, DB, 0);
        cyc(1'b0, 1'b1, 1'b0);
        chk("t4.word_out",   bus_e.word_out,   8'hFF);
        chk("t4.parity_err", bus_e.parity_err, 0);

        // 5: asynchronous reset mid-frame
        cyc(1'b1, 1'b0, 1'b0);
        send_bits(8'h15, 5, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5.word_out",    bus_e.word_out,    0);
        chk("t5.busy",        bus_e.busy,        0);
        chk("t5.frame_abort", bus_e.frame_abort, 0);
        chk("t5.parity_err",  bus_e.parity_err,  0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send_frame(8'h3C, 1'b0, 0);
        chk("t5.word_out2",   bus_e.word_out,   8'h3C);
        chk("t5.parity_err2", bus_e.parity_err, 0);

        // 6: odd parity, back-to-back frame started in REPORT
        send_frame(8'h00, 1'b1, 0);
        chk("t6.word_valid", bus_o.word_valid, 1);
        chk("t6.parity_err", bus_o.parity_err, 0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("t6.no_abort",   bus_o.frame_abort, 0);
        chk("t6.busy",       bus_o.busy,        1);
        send_bits(8'h80, DB, 0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("t6.word_valid2", bus_o.word_valid, 1);
        chk("t6.word_out2",   bus_o.word_out,   8'h80);
        chk("t6.parity_err2", bus_o.parity_err, 1);
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
- Downstream consumer of the XOR gate stage: takes a serial bit stream, one bit per `bit_valid` strobe.
- Frames each stream as DATA_BITS data bits, LSB first, followed by one parity bit.
- For each frame, reports the parallel word plus a parity-error flag.
- Sits between the serial XOR/scramble logic and any parallel word consumer.

Parameters:
DATA_BITS, 8, number of data bits per frame (legal range 2..32)
ODD_PARITY, 0, 0 = even parity (XOR of all DATA_BITS+1 bits must be 0); 1 = odd parity (XOR must be 1)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
frame_start  input  1  one-cycle pulse marking start of a new frame; never carries a bit
bit_in  input  1  serial data/parity bit
bit_valid  input  1  bit_in is sampled on this cycle
word_out  output  DATA_BITS  last completed data word, LSB = first received bit
word_valid  output  1  one-cycle pulse; word_out/parity_err valid this cycle
parity_err  output  1  parity result, qualified by word_valid
busy  output  1  high in DATA and PARITY states
frame_abort  output  1  one-cycle pulse; active frame was discarded by a new frame_start

Behaviour:
- Reset:
  - rst_n low, asynchronous: state=IDLE, bit count=0, parity accumulator=0.
  - word_out=0, word_valid=0, parity_err=0, busy=0, frame_abort=0.
  - Reset mid-frame discards the partial frame silently; no abort pulse.
- FSM states:
  - IDLE:
    - frame_start -> DATA: count=0, shift register and accumulator cleared.
    - bit_valid in IDLE is ignored.
    - bit_valid in the frame_start cycle is ignored.
  - DATA:
    - On bit_valid, shift bit_in into position count (LSB first), accumulator ^= bit_in, count++.
    - When bit_valid arrives with count==DATA_BITS-1 -> PARITY.
    - Cycles without bit_valid hold state; gaps are unbounded.
  - PARITY:
    - On bit_valid, parity_err_next = (accumulator ^ bit_in) != ODD_PARITY.
    - word register loads the shift register -> REPORT.
  - REPORT: exactly one cycle.
    - word_valid=1; parity_err and word_out show the frame result.
    - Next state is IDLE, or DATA if frame_start is high in this cycle (back-to-back frames, no abort).
    - bit_valid in REPORT is ignored.
- Latency: word_valid rises one cycle after the cycle the parity bit is sampled.
- Output registers and hold rules:
  - word_out holds its value until the next REPORT.
  - parity_err holds likewise, but is meaningful only with word_valid.
- Abort:
  - frame_start in DATA or PARITY restarts the frame: -> DATA, count and accumulator cleared.
  - frame_abort pulses high in the following cycle.
  - No word_valid for the aborted frame.
  - word_out is unchanged.
- Simultaneous events:
  - frame_start has priority over bit_valid in every state.
  - A bit arriving with frame_start is dropped.
- Widths and registering:
  - Count width is $clog2(DATA_BITS); the counter never wraps, because the state leaves DATA at DATA_BITS-1.
  - All outputs are registered (no combinational path from inputs).
- busy=1 in DATA and PARITY; busy=0 in IDLE and REPORT.

Decomposition:
- Package serial_parity_pkg holds:
  - the state typedef (IDLE, DATA, PARITY, REPORT);
  - the parity-mode constants EVEN_PARITY=0 and ODD_PARITY_MODE=1.
- One sub-module, parity_accum:
  - 1-bit XOR accumulator with sync clear, enable, and async active-low reset;
  - reused later by the parity generator.
- Counter and shift register stay inline.

Test Plan:
1. Defaults; frame_start, bits 1,0,1,0,0,1,0,1 (0xA5), parity 0 -> word_out=0xA5, word_valid one cycle after parity bit, parity_err=0, busy low in REPORT.
2. Same data, parity bit 1 -> word_out=0xA5, parity_err=1, word_valid single-cycle pulse.
3. 0x01 with 3 idle cycles between every bit_valid, parity 1 -> word_out=0x01, parity_err=0; busy high throughout the gaps.
4. Four bits of a frame, then frame_start -> frame_abort pulse next cycle, no word_valid, word_out holds the previous value. Then 0xFF with parity 0 -> word_out=0xFF, parity_err=0.
5. rst_n low after five data bits -> all outputs 0 immediately, state IDLE. Then 0x3C with parity 0 -> word_out=0x3C, parity_err=0.
6. ODD_PARITY=1:
   - 0x00 with parity 1 -> parity_err=0.
   - frame_start asserted in the REPORT cycle, then 0x80 with parity 1 -> second word_valid reports 0x80, parity_err=1, no frame_abort.
